// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default widths and
// the FSM state encoding.
package rf_dump_reader_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : rf_dump_reader_pkg

// File: rtl/rf_dump_reader.sv
// Walks an inclusive, wrapping address range on one register-file read port
// and presents each (address, data) word on a valid/ready output stream.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ra_lo,
  input  logic [ADDR_W-1:0] ra_hi,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] hi_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  logic handshake;
  logic last_word;

  // Outputs are decoded from registered state only, so an asynchronous
  // reset clears them immediately without waiting for a clock edge.
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rf_ra     = cur_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  assign handshake = out_valid & out_ready;
  assign last_word = (cur_q == hi_q);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is assigned a default before the case so no path through
  // this block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_READ;
      ST_READ: state_d = ST_HOLD;
      ST_HOLD: begin
        if (handshake) begin
          state_d = last_word ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Range bounds are captured once at acceptance; later ra_lo/ra_hi activity
  // and start pulses while busy cannot disturb a dump in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q      <= '0;
      hi_q       <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_q <= ra_lo;
            hi_q  <= ra_hi;
          end
        end
        ST_READ: begin
          // The only capture point for data: later writes to the register
          // file cannot alter a word already on the output.
          out_addr_q <= cur_q;
          out_data_q <= rf_rd;
        end
        ST_HOLD: begin
          if (handshake && !last_word) begin
            cur_q <= cur_q + ADDR_W'(1);
          end
        end
        ST_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule : rf_dump_reader
